pipeline_hazard_controller: RTL and testbench

- Central stall/flush sequencer for the 5-stage MIPS pipeline, between the ID-stage Controller and the IF/ID, ID/EX and EX/MEM pipeline registers.
- Resolves three hazard classes:
  - load-use hazards (1-cycle bubble);
  - multi-cycle mul occupancy of EX (FSM-timed freeze);
  - control flushes for taken branches and jumps.
- Drives the Controller's hazardjump input.
- Keeps saturating stall/flush counters for performance debug.

---
 rtl/pipeline_hazard_controller_pkg.sv | 14 +
 rtl/pipeline_hazard_controller_mul.sv | 57 +++++
 rtl/pipeline_hazard_controller.sv | 110 +++++++++++
 tb/tb_pipeline_hazard_controller.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared constants for the pipeline hazard controller and its mul timer.
package pipeline_hazard_controller_pkg;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MUL_BUSY = 1'b1
  } mul_state_e;

  localparam int unsigned MUL_LATENCY_DEF = 3;
  localparam int unsigned CNT_W_DEF       = 16;
  localparam int unsigned REG_W           = 5;
  localparam logic [REG_W-1:0] REG_ZERO   = 5'd0;

endpackage

// File: rtl/pipeline_hazard_controller_mul.sv
// RUN/MUL_BUSY sequencer that freezes the front of the pipe while a mul occupies EX.
module hazard_mul_timer
  import pipeline_hazard_controller_pkg::*;
#(
  parameter int unsigned MUL_LATENCY = MUL_LATENCY_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic ex_is_mul,
  output logic mul_stall,
  output logic mul_busy
);

  localparam int unsigned MCNT_W    = $clog2(MUL_LATENCY) + 1;
  localparam int unsigned MCNT_INIT = (MUL_LATENCY >= 2) ? (MUL_LATENCY - 2) : 0;
  localparam bit          MUL_STALLS = (MUL_LATENCY >= 2);

  mul_state_e        state_q, state_d;
  logic [MCNT_W-1:0] mcnt_q, mcnt_d;

  // State and remaining-stall counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      mcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      mcnt_q  <= mcnt_d;
    end
  end

  // Next state, stall request and busy flag.
  always_comb begin
    state_d   = state_q;
    mcnt_d    = mcnt_q;
    mul_stall = 1'b0;
    mul_busy  = (state_q == ST_MUL_BUSY);
    case (state_q)
      ST_RUN: begin
        if (ex_is_mul && MUL_STALLS) begin
          mul_stall = 1'b1;
          state_d   = ST_MUL_BUSY;
          mcnt_d    = MCNT_W'(MCNT_INIT);
        end
      end
      ST_MUL_BUSY: begin
        if (mcnt_q != '0) begin
          mul_stall = 1'b1;
          mcnt_d    = mcnt_q - MCNT_W'(1);
        end else begin
          state_d = ST_RUN;
        end
      end
    endcase
  end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: mul freeze, load-use bubble,
// branch/jump flushes, plus saturating stall and flush counters.
module pipeline_hazard_controller
  import pipeline_hazard_controller_pkg::*;
#(
  parameter int unsigned MUL_LATENCY = MUL_LATENCY_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             id_jump,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_dest,
  input  logic             ex_is_mul,
  input  logic             ex_branch_taken,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             hazard_jump,
  output logic             mul_busy,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             mul_stall;
  logic             load_use;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  hazard_mul_timer #(
    .MUL_LATENCY (MUL_LATENCY)
  ) u_mul_timer (
    .clk       (clk),
    .rst       (rst),
    .ex_is_mul (ex_is_mul),
    .mul_stall (mul_stall),
    .mul_busy  (mul_busy)
  );

  // Load in EX writing a register the instruction in ID reads; r0 never hazards.
  always_comb begin
    load_use = id_valid && ex_mem_read && (ex_dest != REG_ZERO) &&
               ((ex_dest == id_rs) || (id_uses_rt && (ex_dest == id_rt)));
  end

  // Priority: reset > mul stall > taken branch > load-use > jump.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    hazard_jump = 1'b0;
    if (rst) begin
      pc_write = 1'b1;
    end else if (mul_stall) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_flush = 1'b1;
    end else if (ex_branch_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (load_use) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_flush = 1'b1;
    end else if (id_valid && id_jump) begin
      ifid_flush  = 1'b1;
      hazard_jump = 1'b1;
    end
  end

  // Saturating counter next values.
  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (!pc_write && (stall_q != CNT_MAX)) begin
      stall_d = stall_q + CNT_W'(1);
    end
    if ((ifid_flush || idex_flush || exmem_flush) && (flush_q != CNT_MAX)) begin
      flush_d = flush_q + CNT_W'(1);
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign stall_count = stall_q;
  assign flush_count = flush_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller (MUL_LATENCY=3, CNT_W=4) with a
// MUL_LATENCY=1 instance sharing the same stimulus.
module tb_pipeline_hazard_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_uses_rt, id_jump;
  logic [4:0] id_rs, id_rt, ex_dest;
  logic       ex_mem_read, ex_is_mul, ex_branch_taken;

  logic       pc_write, ifid_write, idex_write, ifid_flush, idex_flush;
  logic       exmem_flush, hazard_jump, mul_busy;
  logic [3:0] stall_count, flush_count;

  logic       pc_write1, ifid_write1, idex_write1, ifid_flush1, idex_flush1;
  logic       exmem_flush1, hazard_jump1, mul_busy1;
  logic [3:0] stall_count1, flush_count1;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pipeline_hazard_controller #(.MUL_LATENCY(3), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .id_jump(id_jump), .ex_mem_read(ex_mem_read),
    .ex_dest(ex_dest), .ex_is_mul(ex_is_mul), .ex_branch_taken(ex_branch_taken),
    .pc_write(pc_write), .ifid_write(ifid_write), .idex_write(idex_write),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .hazard_jump(hazard_jump), .mul_busy(mul_busy),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  pipeline_hazard_controller #(.MUL_LATENCY(1), .CNT_W(4)) dut1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .id_jump(id_jump), .ex_mem_read(ex_mem_read),
    .ex_dest(ex_dest), .ex_is_mul(ex_is_mul), .ex_branch_taken(ex_branch_taken),
    .pc_write(pc_write1), .ifid_write(ifid_write1), .idex_write(idex_write1),
    .ifid_flush(ifid_flush1), .idex_flush(idex_flush1), .exmem_flush(exmem_flush1),
    .hazard_jump(hazard_jump1), .mul_busy(mul_busy1),
    .stall_count(stall_count1), .flush_count(flush_count1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_valid = 1'b0; id_uses_rt = 1'b0; id_jump = 1'b0;
    id_rs = 5'd0; id_rt = 5'd0; ex_dest = 5'd0;
    ex_mem_read = 1'b0; ex_is_mul = 1'b0; ex_branch_taken = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
  endtask

  // Packed write/flush/jump/busy outputs: {pc,ifid_w,idex_w,ifid_f,idex_f,exmem_f,hj,busy}
  function automatic logic [7:0] ctl();
    return {pc_write, ifid_write, idex_write, ifid_flush, idex_flush,
            exmem_flush, hazard_jump, mul_busy};
  endfunction

  initial begin
    clear_inputs();
    rst = 1'b1;
    #3;
    chk("reset_ctl", 32'(ctl()), 32'b1110_0000);
    chk("reset_cnt", {24'd0, stall_count, flush_count}, 32'd0);
    step();
    rst = 1'b0;
    #1;

    // Load-use on rs
    id_valid = 1'b1; ex_mem_read = 1'b1; ex_dest = 5'd8; id_rs = 5'd8;
    #1;
    chk("lu_rs_ctl", 32'(ctl()), 32'b0010_1000);
    step();
    clear_inputs();
    #1;
    chk("lu_after_ctl", 32'(ctl()), 32'b1110_0000);
    chk("lu_cnt", {24'd0, stall_count, flush_count}, {24'd0, 4'd1, 4'd1});

    // ex_dest = r0 never stalls
    id_valid = 1'b1; ex_mem_read = 1'b1; ex_dest = 5'd0; id_rs = 5'd0;
    #1;
    chk("lu_r0_ctl", 32'(ctl()), 32'b1110_0000);
    step();

    // rt match only counts when the instruction reads rt
    ex_dest = 5'd9; id_rt = 5'd9; id_rs = 5'd3; id_uses_rt = 1'b0;
    #1;
    chk("lu_rt_unused", 32'(pc_write), 32'd1);
    id_uses_rt = 1'b1;
    #1;
    chk("lu_rt_used", 32'(ctl()), 32'b0010_1000);
    step();
    id_valid = 1'b0;
    #1;
    chk("lu_bubble_in_id", 32'(pc_write), 32'd1);
    step();
    chk("lu_cnt2", {24'd0, stall_count, flush_count}, {24'd0, 4'd2, 4'd2});

    // Mul, latency 3: two stall cycles, advance on the third
    clear_inputs();
    do_reset();
    ex_is_mul = 1'b1;
    #1;
    chk("mul_c1", 32'(ctl()), 32'b0000_0100);
    chk("lat1_all", {14'd0, ctl1(), stall_count1, flush_count1}, {14'd0, 8'b1110_0000, 8'd0});
    step();
    chk("mul_c2", 32'(ctl()), 32'b0000_0101);
    chk("lat1_busy", 32'(mul_busy1), 32'd0);
    step();
    chk("mul_c3", 32'(ctl()), 32'b1110_0001);
    step();
    ex_is_mul = 1'b0;
    #1;
    chk("mul_done", 32'(ctl()), 32'b1110_0000);
    chk("mul_cnt", {24'd0, stall_count, flush_count}, {24'd0, 4'd2, 4'd2});

    // Jump held across a mul stall
    do_reset();
    ex_is_mul = 1'b1; id_valid = 1'b1; id_jump = 1'b1;
    #1;
    chk("jmp_stall1", 32'(ctl()), 32'b0000_0100);
    step();
    chk("jmp_stall2", 32'(ctl()), 32'b0000_0101);
    step();
    chk("jmp_release", 32'(ctl()), 32'b1111_0011);
    step();
    clear_inputs();
    #1;
    chk("jmp_done", 32'(ctl()), 32'b1110_0000);
    chk("jmp_cnt", {24'd0, stall_count, flush_count}, {24'd0, 4'd2, 4'd3});

    // Reset in the second MUL_BUSY cycle
    do_reset();
    ex_is_mul = 1'b1;
    step();
    step();
    chk("rmid_busy", 32'(mul_busy), 32'd1);
    chk("rmid_cnt_pre", {24'd0, stall_count, flush_count}, {24'd0, 4'd2, 4'd2});
    rst = 1'b1;
    #1;
    chk("rmid_ctl", 32'(ctl()), 32'b1110_0000);
    chk("rmid_cnt", {24'd0, stall_count, flush_count}, 32'd0);
    step();
    rst = 1'b0;
    ex_is_mul = 1'b0;
    #1;
    chk("rmid_run", 32'(ctl()), 32'b1110_0000);
    ex_is_mul = 1'b1;
    #1;
    chk("rmid_newmul", 32'(ctl()), 32'b0000_0100);
    step();
    step();
    step();
    ex_is_mul = 1'b0;

    // Taken branch overrides load-use and jump
    clear_inputs();
    do_reset();
    id_valid = 1'b1; ex_mem_read = 1'b1; ex_dest = 5'd8; id_rs = 5'd8;
    id_jump = 1'b1; ex_branch_taken = 1'b1;
    #1;
    chk("br_ctl", 32'(ctl()), 32'b1111_1000);
    step();
    clear_inputs();
    #1;
    chk("br_cnt", {24'd0, stall_count, flush_count}, {24'd0, 4'd0, 4'd1});

    // Plain jump
    id_valid = 1'b1; id_jump = 1'b1;
    #1;
    chk("jmp_plain", 32'(ctl()), 32'b1111_0010);
    step();
    // Load-use beats jump
    ex_mem_read = 1'b1; ex_dest = 5'd4; id_rs = 5'd4;
    #1;
    chk("lu_over_jmp", 32'(ctl()), 32'b0010_1000);
    step();
    clear_inputs();
    id_jump = 1'b1;
    #1;
    chk("jmp_bubble", 32'(ctl()), 32'b1110_0000);
    chk("jmp_lu_cnt", {24'd0, stall_count, flush_count}, {24'd0, 4'd1, 4'd3});

    // Saturation at 15 with CNT_W=4
    clear_inputs();
    do_reset();
    id_valid = 1'b1; ex_mem_read = 1'b1; ex_dest = 5'd8; id_rs = 5'd8;
    repeat (14) step();
    chk("sat_14", 32'(stall_count), 32'd14);
    step();
    chk("sat_15", 32'(stall_count), 32'd15);
    repeat (5) step();
    chk("sat_hold", {24'd0, stall_count, flush_count}, {24'd0, 4'd15, 4'd15});
    clear_inputs();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  function automatic logic [7:0] ctl1();
    return {pc_write1, ifid_write1, idex_write1, ifid_flush1, idex_flush1,
            exmem_flush1, hazard_jump1, mul_busy1};
  endfunction

endmodule
